// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared game-state codes, scheduler FSM encoding and pending-tick limit
// for the enemy spawn scheduler.
package enemy_spawn_scheduler_pkg;

   localparam logic [2:0] STATE_PLAY        = 3'b001;
   localparam logic [2:0] STATE_TITLE       = 3'b100;
   localparam logic [1:0] SPAWN_PENDING_MAX = 2'd3;

   typedef enum logic [1:0] {
      SCHED_IDLE  = 2'b00,
      SCHED_PICK  = 2'b01,
      SCHED_ISSUE = 2'b10
   } sched_state_t;

endpackage

// File: rtl/enemy_spawn_scheduler_arbiter.sv
// Combinational first-free slot search starting at a round-robin pointer,
// wrapping past the last slot back to slot 0.
module slot_rr_arbiter
   import enemy_spawn_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] slot_free,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_SLOTS-1:0] grant,
   output logic [IDX_W-1:0]     index,
   output logic                 found
);

   logic [IDX_W-1:0] cand_s;

   // Walk the slots from ptr onward and grant the first free one
   always_comb begin
      grant  = {NUM_SLOTS{1'b0}};
      index  = {IDX_W{1'b0}};
      found  = 1'b0;
      cand_s = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cand_s = IDX_W'((int'(ptr) + i) % NUM_SLOTS);
         if (!found && slot_free[cand_s]) begin
            grant         = {NUM_SLOTS{1'b0}};
            grant[cand_s] = 1'b1;
            index         = cand_s;
            found         = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Turns spawn-counter ticks into one-per-frame spawn commands: queues ticks,
// picks a free slot round-robin, clamps a PRBS X and hands off via valid/ready.
module enemy_spawn_scheduler
   import enemy_spawn_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int X_W       = 10,
   parameter int X_MIN     = 16,
   parameter int X_MAX     = 608
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enb,
   input  logic                 pixel_0_line_0,
   input  logic [2:0]           state,
   input  logic                 spawn_tick,
   input  logic [X_W-1:0]       prbs_val,
   input  logic [NUM_SLOTS-1:0] slot_busy,
   output logic                 spawn_valid,
   input  logic                 spawn_ready,
   output logic [NUM_SLOTS-1:0] spawn_slot,
   output logic [X_W-1:0]       spawn_x,
   output logic                 global_tick,
   output logic                 spawn_overflow
);

   localparam int             IDX_W    = $clog2(NUM_SLOTS);
   localparam logic [X_W-1:0] X_MIN_V  = X_W'(X_MIN);
   localparam logic [X_W-1:0] X_MAX_V  = X_W'(X_MAX);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

   function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v);
      logic [X_W-1:0] r;
      if (v < X_MIN_V) begin
         r = X_MIN_V;
      end else if (v > X_MAX_V) begin
         r = X_MAX_V;
      end else begin
         r = v;
      end
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
      logic [IDX_W-1:0] r;
      if (i == LAST_IDX) begin
         r = {IDX_W{1'b0}};
      end else begin
         r = i + IDX_W'(1);
      end
      return r;
   endfunction

   sched_state_t         fsm_r, fsm_nxt;
   logic [1:0]           pending_r, pending_nxt;
   logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_nxt;
   logic [IDX_W-1:0]     idx_r, idx_nxt;
   logic                 tick_d_r;
   logic                 spawn_valid_r, spawn_valid_nxt;
   logic [NUM_SLOTS-1:0] spawn_slot_r, spawn_slot_nxt;
   logic [X_W-1:0]       spawn_x_r, spawn_x_nxt;
   logic                 global_tick_r, global_tick_nxt;
   logic                 overflow_r, overflow_nxt;

   logic                 play_s, tick_edge_s, inc_s, hs_s;
   logic [NUM_SLOTS-1:0] grant_s;
   logic [IDX_W-1:0]     grant_idx_s;
   logic                 found_s;

   slot_rr_arbiter #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_arb (
      .slot_free (~slot_busy),
      .ptr       (rr_ptr_r),
      .grant     (grant_s),
      .index     (grant_idx_s),
      .found     (found_s)
   );

   // Next-state, pending-count and output-register logic
   always_comb begin
      play_s      = (state == STATE_PLAY);
      tick_edge_s = spawn_tick & ~tick_d_r;
      inc_s       = tick_edge_s & enb & play_s;
      hs_s        = spawn_valid_r & spawn_ready;

      fsm_nxt         = fsm_r;
      pending_nxt     = pending_r;
      rr_ptr_nxt      = rr_ptr_r;
      idx_nxt         = idx_r;
      spawn_slot_nxt  = spawn_slot_r;
      spawn_x_nxt     = spawn_x_r;
      global_tick_nxt = 1'b0;
      overflow_nxt    = 1'b0;

      if (!play_s) begin
         // Leaving PLAY abandons any in-flight command outright
         fsm_nxt     = SCHED_IDLE;
         pending_nxt = 2'd0;
         rr_ptr_nxt  = {IDX_W{1'b0}};
      end else begin
         if (inc_s && hs_s) begin
            pending_nxt = pending_r;
         end else if (inc_s) begin
            if (pending_r == SPAWN_PENDING_MAX) begin
               overflow_nxt = 1'b1;
            end else begin
               pending_nxt = pending_r + 2'd1;
            end
         end else if (hs_s) begin
            pending_nxt = pending_r - 2'd1;
         end else begin
            pending_nxt = pending_r;
         end

         // The handshake completes even while enb is low
         if (hs_s) begin
            global_tick_nxt = 1'b1;
            rr_ptr_nxt      = next_ptr(idx_r);
            fsm_nxt         = SCHED_IDLE;
         end else if (!enb) begin
            fsm_nxt = fsm_r;
         end else begin
            case (fsm_r)
               SCHED_IDLE: begin
                  if (pixel_0_line_0 && (pending_r != 2'd0)) begin
                     fsm_nxt = SCHED_PICK;
                  end else begin
                     fsm_nxt = SCHED_IDLE;
                  end
               end
               SCHED_PICK: begin
                  if (found_s) begin
                     spawn_slot_nxt = grant_s;
                     idx_nxt        = grant_idx_s;
                     spawn_x_nxt    = clamp_x(prbs_val);
                     fsm_nxt        = SCHED_ISSUE;
                  end else begin
                     fsm_nxt = SCHED_IDLE;
                  end
               end
               SCHED_ISSUE: fsm_nxt = SCHED_ISSUE;
               default:     fsm_nxt = SCHED_IDLE;
            endcase
         end
      end

      spawn_valid_nxt = (fsm_nxt == SCHED_ISSUE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_r         <= SCHED_IDLE;
         pending_r     <= 2'd0;
         rr_ptr_r      <= {IDX_W{1'b0}};
         idx_r         <= {IDX_W{1'b0}};
         tick_d_r      <= 1'b0;
         spawn_valid_r <= 1'b0;
         spawn_slot_r  <= {NUM_SLOTS{1'b0}};
         spawn_x_r     <= X_MIN_V;
         global_tick_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         fsm_r         <= fsm_nxt;
         pending_r     <= pending_nxt;
         rr_ptr_r      <= rr_ptr_nxt;
         idx_r         <= idx_nxt;
         tick_d_r      <= spawn_tick;
         spawn_valid_r <= spawn_valid_nxt;
         spawn_slot_r  <= spawn_slot_nxt;
         spawn_x_r     <= spawn_x_nxt;
         global_tick_r <= global_tick_nxt;
         overflow_r    <= overflow_nxt;
      end
   end

   assign spawn_valid    = spawn_valid_r;
   assign spawn_slot     = spawn_slot_r;
   assign spawn_x        = spawn_x_r;
   assign global_tick    = global_tick_r;
   assign spawn_overflow = overflow_r;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler: stimulus pushes expected spawn
// commands into a queue; a negedge monitor checks each accepted command.
module tb_enemy_spawn_scheduler;

   logic       clk = 1'b0;
   logic       rst, enb, pixel_0_line_0, spawn_tick, spawn_ready;
   logic [2:0] state;
   logic [9:0] prbs_val;
   logic [7:0] slot_busy;
   logic       spawn_valid, global_tick, spawn_overflow;
   logic [7:0] spawn_slot;
   logic [9:0] spawn_x;

   int errors = 0;
   int checks = 0;
   int ovf_cnt = 0;
   int ovf_base;
   logic [17:0] exp_q[$];

   enemy_spawn_scheduler #(
      .NUM_SLOTS (8), .X_W (10), .X_MIN (16), .X_MAX (608)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enb            (enb),
      .pixel_0_line_0 (pixel_0_line_0),
      .state          (state),
      .spawn_tick     (spawn_tick),
      .prbs_val       (prbs_val),
      .slot_busy      (slot_busy),
      .spawn_valid    (spawn_valid),
      .spawn_ready    (spawn_ready),
      .spawn_slot     (spawn_slot),
      .spawn_x        (spawn_x),
      .global_tick    (global_tick),
      .spawn_overflow (spawn_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted command must match the queue head
   always @(negedge clk) begin
      if (spawn_overflow) ovf_cnt++;
      if (!rst && spawn_valid && spawn_ready && state == 3'b001) begin
         if (exp_q.size() == 0) begin
            check("unexpected_spawn", 32'd1, 32'd0);
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            check("hs_slot", {24'd0, spawn_slot}, {24'd0, e[17:10]});
            check("hs_x", {22'd0, spawn_x}, {22'd0, e[9:0]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      spawn_tick = 1'b1; step();
      spawn_tick = 1'b0; step();
   endtask

   task automatic spawn_and_accept(input logic [9:0] prbs, input logic [7:0] eslot,
                                   input logic [9:0] ex, input string tag);
      prbs_val = prbs;
      exp_q.push_back({eslot, ex});
      pixel_0_line_0 = 1'b1; step();
      pixel_0_line_0 = 1'b0;
      check({tag, "_pick_novalid"}, {31'd0, spawn_valid}, 32'd0);
      step();
      check({tag, "_valid"}, {31'd0, spawn_valid}, 32'd1);
      prbs_val = ~prbs; step();
      spawn_ready = 1'b1; step();
      spawn_ready = 1'b0;
      check({tag, "_gtick"}, {31'd0, global_tick}, 32'd1);
      check({tag, "_valid_drop"}, {31'd0, spawn_valid}, 32'd0);
      step();
      check({tag, "_gtick_once"}, {31'd0, global_tick}, 32'd0);
   endtask

   task automatic reach_issue(input logic [9:0] prbs);
      prbs_val = prbs;
      pixel_0_line_0 = 1'b1; step();
      pixel_0_line_0 = 1'b0; step();
   endtask

   initial begin
      rst = 1'b1; enb = 1'b1; pixel_0_line_0 = 1'b0; spawn_tick = 1'b0;
      spawn_ready = 1'b0; state = 3'b001; prbs_val = 10'd0; slot_busy = 8'h00;
      step(); step();
      rst = 1'b0;
      check("rst_valid", {31'd0, spawn_valid}, 32'd0);
      check("rst_slot", {24'd0, spawn_slot}, 32'd0);
      check("rst_x", {22'd0, spawn_x}, 32'd16);
      check("rst_gtick", {31'd0, global_tick}, 32'd0);
      check("rst_ovf", {31'd0, spawn_overflow}, 32'd0);
      check("rst_pending", {30'd0, dut.pending_r}, 32'd0);

      // Basic spawn
      pulse_tick();
      check("basic_pending", {30'd0, dut.pending_r}, 32'd1);
      spawn_and_accept(10'd300, 8'h01, 10'd300, "basic");
      check("basic_rr", {29'd0, dut.rr_ptr_r}, 32'd1);
      check("basic_pending_dec", {30'd0, dut.pending_r}, 32'd0);

      // Clamp and round-robin
      pulse_tick(); spawn_and_accept(10'd5,    8'h02, 10'd16,  "clamp_lo");
      pulse_tick(); spawn_and_accept(10'd1000, 8'h04, 10'd608, "clamp_hi");
      pulse_tick(); spawn_and_accept(10'd16,   8'h08, 10'd16,  "edge_min");
      pulse_tick(); spawn_and_accept(10'd608,  8'h10, 10'd608, "edge_max");
      check("rr_after_four", {29'd0, dut.rr_ptr_r}, 32'd5);

      // Busy slots: no spawn for three frames
      slot_busy = 8'hFF;
      pulse_tick();
      for (int f = 0; f < 3; f++) begin
         pixel_0_line_0 = 1'b1; step();
         pixel_0_line_0 = 1'b0; step();
         check("busy_novalid", {31'd0, spawn_valid}, 32'd0);
         step();
         check("busy_novalid2", {31'd0, spawn_valid}, 32'd0);
      end
      check("busy_pending", {30'd0, dut.pending_r}, 32'd1);
      slot_busy = 8'hDF;
      spawn_and_accept(10'd450, 8'h20, 10'd450, "free5");
      slot_busy = 8'hFE;
      pulse_tick(); spawn_and_accept(10'd123, 8'h01, 10'd123, "wrap");
      slot_busy = 8'h00;

      // Saturation
      ovf_base = ovf_cnt;
      for (int i = 0; i < 4; i++) begin
         spawn_tick = 1'b1; step();
         spawn_tick = 1'b0;
         check("sat_ovf_pulse", {31'd0, spawn_overflow}, (i == 3) ? 32'd1 : 32'd0);
         check("sat_pending", {30'd0, dut.pending_r}, (i >= 2) ? 32'd3 : 32'(i + 1));
         step();
      end
      check("sat_ovf_count", 32'(ovf_cnt - ovf_base), 32'd1);

      // Tick edge coincident with handshake at pending=3
      exp_q.push_back({8'h02, 10'd200});
      reach_issue(10'd200);
      spawn_tick = 1'b1; spawn_ready = 1'b1; step();
      spawn_tick = 1'b0; spawn_ready = 1'b0;
      check("coinc_gtick", {31'd0, global_tick}, 32'd1);
      check("coinc_pending", {30'd0, dut.pending_r}, 32'd3);
      check("coinc_no_ovf", {31'd0, spawn_overflow}, 32'd0);
      step();
      check("coinc_ovf_count", 32'(ovf_cnt - ovf_base), 32'd1);

      // Abort: TITLE while in ISSUE
      reach_issue(10'd100);
      check("abort_pre_valid", {31'd0, spawn_valid}, 32'd1);
      state = 3'b100; step();
      check("abort_valid", {31'd0, spawn_valid}, 32'd0);
      check("abort_pending", {30'd0, dut.pending_r}, 32'd0);
      check("abort_rr", {29'd0, dut.rr_ptr_r}, 32'd0);
      check("abort_gtick", {31'd0, global_tick}, 32'd0);
      state = 3'b001; step();
      check("abort_no_reissue", {31'd0, spawn_valid}, 32'd0);

      // Reset during ISSUE
      pulse_tick();
      reach_issue(10'd321);
      check("rstmid_pre_valid", {31'd0, spawn_valid}, 32'd1);
      rst = 1'b1; step();
      rst = 1'b0;
      check("rstmid_valid", {31'd0, spawn_valid}, 32'd0);
      check("rstmid_slot", {24'd0, spawn_slot}, 32'd0);
      check("rstmid_x", {22'd0, spawn_x}, 32'd16);
      check("rstmid_pending", {30'd0, dut.pending_r}, 32'd0);
      check("rstmid_rr", {29'd0, dut.rr_ptr_r}, 32'd0);
      check("rstmid_gtick", {31'd0, global_tick}, 32'd0);

      // Enable low over a frame strobe
      pulse_tick();
      enb = 1'b0;
      pulse_tick();
      pixel_0_line_0 = 1'b1; step();
      pixel_0_line_0 = 1'b0; step();
      check("enb_novalid", {31'd0, spawn_valid}, 32'd0);
      check("enb_pending", {30'd0, dut.pending_r}, 32'd1);
      enb = 1'b1;
      spawn_and_accept(10'd400, 8'h01, 10'd400, "enb_resume");

      // Handshake accepted while enb is low
      pulse_tick();
      exp_q.push_back({8'h02, 10'd555});
      reach_issue(10'd555);
      enb = 1'b0; spawn_ready = 1'b1; step();
      spawn_ready = 1'b0;
      check("enb0_hs_gtick", {31'd0, global_tick}, 32'd1);
      check("enb0_hs_valid", {31'd0, spawn_valid}, 32'd0);
      check("enb0_hs_pending", {30'd0, dut.pending_r}, 32'd0);
      enb = 1'b1; step();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/enemy_spawn_scheduler.md
# enemy_spawn_scheduler

- Converts spawn ticks from the enemy spawn counter into concrete spawn commands for the enemy bank.
- Queues ticks and picks a free enemy slot round-robin, once per frame.
- Derives a clamped X position from the shared PRBS and hands the command over with a valid/ready handshake.
- Pulses `global_tick` back to the spawn counter so it reloads a new random period after each accepted spawn.

## Interface

Parameters:
- `NUM_SLOTS`, 8: number of enemy slots in the bank (2..16).
- `X_W`, 10: width of the X coordinate.
- `X_MIN`, 16: leftmost legal spawn X.
- `X_MAX`, 608: rightmost legal spawn X.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  synchronous active-high reset.
- `enb`  in  1  gameplay enable; when 0, FSM and queue hold.
- `pixel_0_line_0`  in  1  one-cycle frame-start strobe.
- `state`  in  3  game state; `STATE_PLAY`=3'b001, `STATE_TITLE`=3'b100.
- `spawn_tick`  in  1  tick from the spawn counter (may stay high one frame).
- `prbs_val`  in  X_W  free-running PRBS output.
- `slot_busy`  in  NUM_SLOTS  1 = slot holds a live enemy.
- `spawn_valid`  out  1  spawn command valid.
- `spawn_ready`  in  1  enemy bank accepts the command.
- `spawn_slot`  out  NUM_SLOTS  one-hot target slot, valid with `spawn_valid`.
- `spawn_x`  out  X_W  spawn X, valid with `spawn_valid`.
- `global_tick`  out  1  one-cycle pulse on handshake; spawn counter reloads its period.
- `spawn_overflow`  out  1  one-cycle pulse when a tick is dropped.

## Operation

Tick capture:
- A rising edge of `spawn_tick`, with `enb`=1 and `state`==PLAY, increments `pending`.
- `pending` is a 2-bit counter that saturates at 3.
- A tick arriving while saturated is dropped and pulses `spawn_overflow`.

FSM states: IDLE, PICK, ISSUE.
- **IDLE**: on `pixel_0_line_0` && `enb` && `pending`≠0 && PLAY → PICK.
- **PICK** (1 cycle):
  - Search `~slot_busy` starting at `rr_ptr` and wrapping.
  - Free slot found → latch the one-hot slot, latch the clamped X from `prbs_val`, go to ISSUE.
  - All slots busy → IDLE; `pending` is kept and retried next frame.
- **ISSUE**:
  - `spawn_valid`=1; `spawn_slot` and `spawn_x` are held stable until the handshake.
  - On `spawn_valid`&&`spawn_ready`:
    - `pending`−1;
    - `rr_ptr` ← chosen index+1 mod NUM_SLOTS;
    - `global_tick` pulse;
    - → IDLE.

X clamp:
- `prbs_val` < X_MIN → X_MIN.
- `prbs_val` > X_MAX → X_MAX.
- Otherwise `prbs_val` unchanged (unsigned compare).

Boundary conditions:
- A tick edge and a handshake in the same cycle leave `pending` unchanged; no overflow if it was at 3 before the decrement.
- `state` leaving PLAY, at any FSM state including ISSUE: next cycle FSM=IDLE, `pending`=0, `rr_ptr`=0, `spawn_valid`=0. An abandoned command is not re-issued.
- TITLE is treated as not PLAY.
- `enb`=0 freezes the FSM, `pending`, `rr_ptr`, and held outputs. A handshake is still accepted while `enb`=0, so a bank in the middle of a handshake is never stalled.
- Reset mid-operation: same as the reset values below, from the next edge.

Reset values:
- FSM=IDLE, `pending`=0, `rr_ptr`=0.
- `spawn_valid`=0, `spawn_slot`=0, `spawn_x`=X_MIN.
- `global_tick`=0, `spawn_overflow`=0.

## Timing

- All outputs are registered.
- Frame strobe at cycle N (IDLE, pending>0) → PICK at N+1 → `spawn_valid`=1 from N+2.
- Handshake at cycle M → `global_tick`=1 during M+1 only; FSM in IDLE at M+1.
- At most one spawn per frame: after returning to IDLE, a new PICK needs the next `pixel_0_line_0`.
- `spawn_overflow` is asserted the cycle after the dropped tick edge.
- `prbs_val` is sampled only in PICK. Later PRBS changes do not affect the held `spawn_x`.

## Structure

- `define.v` holds:
  - `STATE_PLAY` and `STATE_TITLE`;
  - FSM state encodings `SCHED_IDLE`, `SCHED_PICK`, `SCHED_ISSUE` (2 bits);
  - `SPAWN_PENDING_MAX`=3.
- One sub-module, `slot_rr_arbiter`:
  - combinational first-free search from a pointer, with wrap;
  - outputs a one-hot grant, a binary index, and `found`.
- The top level holds the FSM, `pending`, `rr_ptr`, the clamp, and the output registers.
- Expected size: ~200–300 RTL lines.

## Test plan

Use NUM_SLOTS=8 for all scenarios.
- **Basic spawn**: PLAY, all slots free, one tick, `prbs_val`=300 at PICK.
  - `spawn_valid` 2 cycles after the next frame strobe; `spawn_slot`=8'b0000_0001, `spawn_x`=300.
  - `spawn_ready`=1 → one-cycle `global_tick`; `rr_ptr`=1.
- **Clamp and round-robin**:
  - `prbs_val`=5 → `spawn_x`=16; `prbs_val`=1000 → `spawn_x`=608.
  - Two consecutive spawns with `slot_busy`=0 → slots 0 then 1, on successive frames.
- **Busy slots**:
  - `slot_busy`=8'hFF with pending=1 → no `spawn_valid` over 3 frames, `pending` stays 1.
  - Freeing slot 5 → next frame grants 8'b0010_0000.
- **Saturation**:
  - 4 ticks with `spawn_ready`=0 → `pending`=3, exactly one `spawn_overflow` pulse.
  - A tick in the same cycle as a handshake → `pending` unchanged.
- **Abort**: `state`→TITLE while in ISSUE with `spawn_ready`=0.
  - Next cycle `spawn_valid`=0, `pending`=0, `rr_ptr`=0, no `global_tick`.
- **Reset/enable**:
  - `rst` asserted during ISSUE → all reset values next cycle.
  - `enb`=0 over a frame strobe → no PICK, and `pending` holds.
